// File: rtl/vslc_pkg.sv
// vslc_pkg: opcode fields, stack sub-ops, executor states and reset timer periods
package vslc_pkg;
  localparam logic [1:0] GRP_IO = 2'd0, GRP_SFR = 2'd1, GRP_LOGIC = 2'd2, GRP_EXT = 2'd3;
  localparam logic [1:0] OP_PUSH = 2'd0, OP_POP = 2'd1, OP_SET = 2'd2, OP_RST = 2'd3;
  localparam logic [1:0] LG_TOS = 2'd0, LG_POP2 = 2'd1, LG_NOP = 2'd2, LG_PUSH = 2'd3;
  localparam logic [3:0] SK_CLR = 4'd0, SK_SETALL = 4'd1, SK_SWAP = 4'd2, SK_ROT = 4'd3, SK_EOS = 4'd4;
  localparam int RST_PERIOD_A = 2;
  localparam int RST_PERIOD_B = 3;
  typedef enum logic [1:0] {EXEC, OP_LO, OP_HI} state_t;
endpackage

// File: rtl/vslc_if.sv
// vslc_if: instruction byte stream between fetcher and executor
interface vslc_if;
  logic valid;
  logic ready;
  logic [7:0] instr;
  modport master(output valid, output instr, input ready);
  modport slave(input valid, input instr, output ready);
endinterface

// File: rtl/vslc_timer_gen.sv
// vslc_timer_gen: square wave high period_a ticks then low period_b ticks while enabled
module vslc_timer_gen #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] period_a,
  input  logic [W-1:0] period_b,
  output logic         out
);
  logic [W-1:0] cnt;
  logic [W-1:0] lim;
  logic ph;
  assign lim = ph ? period_a : period_b;
  assign out = en & ph;
  // a zero period still ends the phase after one tick because cnt+1 >= 0 always holds
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ph <= 1'b1;
    end else if (!en) begin
      cnt <= '0;
      ph <= 1'b1;
    end else if (cnt + W'(1) >= lim) begin
      cnt <= '0;
      ph <= ~ph;
    end else cnt <= cnt + W'(1);
endmodule

// File: rtl/tt_um_jimktrains_vslc_exec_param.sv
// tt_um_jimktrains_vslc_exec_param: VSLC bit-stack PLC executor with IO/SFR, logic LUT, edges and timers
module tt_um_jimktrains_vslc_exec_param
  import vslc_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int IO_W = 8,
  parameter int NUM_TIMERS = 2,
  parameter int TIMER_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  vslc_if.slave                  bus,
  input  logic [IO_W-1:0]        ui_in,
  output logic [IO_W-1:0]        uo_out,
  output logic [STACK_DEPTH-1:0] stack_o,
  output logic [5:0]             depth_o,
  output logic                   ovf_o,
  output logic                   unf_o,
  output logic                   scan_done_o
);
  localparam int D = STACK_DEPTH;
  localparam logic [5:0] DMAX = 6'(D);
  state_t state, state_n;
  logic [D-1:0] stk, stk_n;
  logic [5:0] dep, dep_n;
  logic ovf, ovf_n, unf, unf_n, done, done_n;
  logic [7:0] uo, uo_n, lo, lo_n, ui8, prev8, sfr;
  logic [IO_W-1:0] prev, prev_n;
  logic [3:0] ten, ten_n, tout, lut;
  logic [2:0] sel, sel_n, r;
  logic [1:0] op, need;
  logic acc, ld, tos, nos, hos, lf, wv, push, pop, put, pb;
  assign bus.ready = ~rst;
  assign acc = bus.valid & bus.ready;
  assign ld = acc && state == OP_HI;
  assign ui8 = 8'(ui_in);
  assign prev8 = 8'(prev);
  assign r = bus.instr[2:0];
  assign op = bus.instr[5:4];
  assign lut = bus.instr[3:0];
  assign tos = stk[0];
  assign nos = stk[1];
  assign hos = stk[2];
  assign lf = lut[2'd3 - {nos, tos}];
  assign wv = op == OP_POP ? tos : op == OP_SET;
  assign uo_out = uo[IO_W-1:0];
  assign stack_o = stk;
  assign depth_o = dep;
  assign ovf_o = ovf;
  assign unf_o = unf;
  assign scan_done_o = done;
  always_comb
    for (int t = 0; t < 4; t++) begin
      sfr[2*t] = ten[t];
      sfr[2*t+1] = tout[t];
    end
  always_comb begin
    state_n = state;
    stk_n = stk;
    dep_n = dep;
    ovf_n = ovf;
    unf_n = unf;
    done_n = 1'b0;
    uo_n = uo;
    ten_n = ten;
    prev_n = prev;
    lo_n = lo;
    sel_n = sel;
    push = 1'b0;
    pop = 1'b0;
    put = 1'b0;
    pb = 1'b0;
    need = 2'd0;
    if (acc && state == OP_LO) begin
      lo_n = bus.instr;
      state_n = OP_HI;
    end else if (ld) state_n = EXEC;
    else if (acc) begin
      if (!bus.instr[7]) begin
        if (op == OP_PUSH) begin
          push = 1'b1;
          pb = bus.instr[6] ? sfr[r] : bus.instr[3] ? uo[r] : ui8[r];
        end else begin
          pop = 1'b1;
          need = 2'd1;
          if (op == OP_POP || tos) begin
            if (bus.instr[6]) begin
              if (!r[0]) ten_n[r[2:1]] = wv;
            end else if (32'(r) < IO_W) uo_n[r] = wv;
          end
        end
      end else if (bus.instr[7:6] == GRP_LOGIC) begin
        need = op == LG_NOP ? 2'd0 : 2'd2;
        push = op == LG_PUSH;
        pb = lf;
        pop = op == LG_POP2;
        put = op == LG_TOS || op == LG_POP2;
      end else if (!bus.instr[5]) begin
        push = 1'b1;
        pb = prev8[r] == bus.instr[4] && ui8[r] == ~bus.instr[4];
      end else if (!bus.instr[4]) begin
        if (bus.instr[3]) begin
          state_n = OP_LO;
          sel_n = r;
        end
      end else begin
        case (lut)
          SK_CLR: begin
            stk_n = '0;
            dep_n = '0;
            ovf_n = 1'b0;
            unf_n = 1'b0;
          end
          SK_SETALL: begin
            stk_n = '1;
            dep_n = DMAX;
          end
          SK_SWAP: begin
            need = 2'd2;
            stk_n[1:0] = {tos, nos};
          end
          SK_ROT: begin
            need = 2'd3;
            stk_n[2:0] = {tos, hos, nos};
          end
          SK_EOS: begin
            prev_n = ui_in;
            done_n = 1'b1;
          end
          default: ;
        endcase
      end
    end
    if (push) begin
      stk_n = {stk[D-2:0], pb};
      dep_n = dep == DMAX ? dep : dep + 6'd1;
      ovf_n = ovf | dep == DMAX;
    end
    if (pop) begin
      stk_n = {1'b0, stk[D-1:1]};
      dep_n = dep == '0 ? dep : dep - 6'd1;
    end
    if (put) stk_n[0] = lf;
    if (dep < 6'(need)) unf_n = 1'b1;
    // bits above the live depth are always kept 0 so missing operands read as 0
    for (int i = 0; i < D; i++) if (6'(i) >= dep_n) stk_n[i] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EXEC;
      stk <= '0;
      dep <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      done <= 1'b0;
      uo <= '0;
      ten <= '0;
      prev <= '0;
      lo <= '0;
      sel <= '0;
    end else begin
      state <= state_n;
      stk <= stk_n;
      dep <= dep_n;
      ovf <= ovf_n;
      unf <= unf_n;
      done <= done_n;
      uo <= uo_n;
      ten <= ten_n;
      prev <= prev_n;
      lo <= lo_n;
      sel <= sel_n;
    end
  for (genvar g = 0; g < 4; g++) begin : g_tmr
    if (g < NUM_TIMERS) begin : g_on
      logic [TIMER_W-1:0] per_a, per_b;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          per_a <= TIMER_W'(RST_PERIOD_A);
          per_b <= TIMER_W'(RST_PERIOD_B);
        end else if (ld && sel[1:0] == 2'(g)) begin
          if (sel[2]) per_b <= {bus.instr[TIMER_W-9:0], lo};
          else per_a <= {bus.instr[TIMER_W-9:0], lo};
        end
      vslc_timer_gen #(.W(TIMER_W)) u_tmr (
        .clk(clk),
        .rst(rst),
        .en(ten[g]),
        .period_a(per_a),
        .period_b(per_b),
        .out(tout[g])
      );
    end else begin : g_off
      assign tout[g] = 1'b0;
    end
  end
endmodule

// File: tb/tb_tt_um_jimktrains_vslc_exec_param.sv
// tb_tt_um_jimktrains_vslc_exec_param: directed checks of stack, IO, edges, timers and idle behaviour
module tb_tt_um_jimktrains_vslc_exec_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [15:0] stack_o;
  logic [5:0] depth_o;
  logic ovf_o, unf_o, scan_done_o;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] e, s_snap;
  logic [7:0] u_snap;
  logic [5:0] d_snap;
  vslc_if bus();
  tt_um_jimktrains_vslc_exec_param dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .stack_o(stack_o),
    .depth_o(depth_o),
    .ovf_o(ovf_o),
    .unf_o(unf_o),
    .scan_done_o(scan_done_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [7:0] b);
    bus.valid = 1'b1;
    bus.instr = b;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask
  task automatic push_sfr3(input int n);
    bus.valid = 1'b1;
    bus.instr = 8'h43;
    repeat (n) @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask
  initial begin
    bus.valid = 1'b0;
    bus.instr = 8'h00;
    #12;
    check("ready_in_rst", 32'(bus.ready), 0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("rst_stack", 32'(stack_o), 0);
    check("rst_depth", 32'(depth_o), 0);
    check("rst_flags", {29'd0, ovf_o, unf_o, scan_done_o}, 0);
    check("rst_uo", 32'(uo_out), 0);
    check("ready", 32'(bus.ready), 1);
    ui_in = 8'h01;
    step(8'h00);
    step(8'h01);
    step(8'h91);
    check("and_stack", 32'(stack_o), 0);
    check("and_depth", 32'(depth_o), 1);
    check("and_unf", 32'(unf_o), 0);
    step(8'h00);
    step(8'h96);
    check("xor_stack", 32'(stack_o), 1);
    check("xor_depth", 32'(depth_o), 1);
    rst = 1'b1;
    #2;
    @(negedge clk) rst = 1'b0;
    step(8'h96);
    check("unf_set", 32'(unf_o), 1);
    check("unf_depth", 32'(depth_o), 0);
    step(8'hF0);
    check("clr_unf", 32'(unf_o), 0);
    repeat (16) step(8'h00);
    check("full_ovf", 32'(ovf_o), 0);
    check("full_depth", 32'(depth_o), 16);
    step(8'h00);
    check("ovf_set", 32'(ovf_o), 1);
    check("ovf_depth", 32'(depth_o), 16);
    check("ovf_stack", 32'(stack_o), 32'hFFFF);
    step(8'h11);
    check("pop_uo", 32'(uo_out), 32'h02);
    step(8'h31);
    check("reset_uo", 32'(uo_out), 0);
    step(8'h27);
    check("set_uo", 32'(uo_out), 32'h80);
    check("set_depth", 32'(depth_o), 13);
    step(8'hF0);
    check("clr_all", {16'd0, stack_o}, 0);
    check("clr_ovf", 32'(ovf_o), 0);
    ui_in = 8'h00;
    step(8'hF4);
    check("eos_pulse", 32'(scan_done_o), 1);
    @(posedge clk);
    #1;
    check("eos_once", 32'(scan_done_o), 0);
    ui_in = 8'h04;
    step(8'hC2);
    check("rise_stack", 32'(stack_o), 1);
    step(8'hD2);
    check("fall_stack", 32'(stack_o), 2);
    check("edge_depth", 32'(depth_o), 2);
    step(8'hF0);
    step(8'hF1);
    check("setall_stack", 32'(stack_o), 32'hFFFF);
    check("setall_depth", 32'(depth_o), 16);
    step(8'hF0);
    ui_in = 8'h01;
    step(8'h00);
    step(8'h01);
    step(8'hF2);
    check("swap_stack", 32'(stack_o), 1);
    step(8'h01);
    step(8'hF3);
    check("rot_stack", 32'(stack_o), 1);
    check("rot_depth", 32'(depth_o), 3);
    step(8'hF0);
    step(8'hED);
    step(8'h05);
    step(8'h00);
    check("load_no_decode", 32'(depth_o), 0);
    step(8'h00);
    step(8'h52);
    check("en_pop_depth", 32'(depth_o), 0);
    push_sfr3(14);
    e = 16'h0;
    for (int k = 0; k < 14; k++) e[13-k] = (k % 7) < 2;
    check("timer_2_5", 32'(stack_o), 32'(e));
    check("timer_depth", 32'(depth_o), 14);
    step(8'hF0);
    step(8'hED);
    step(8'h09);
    rst = 1'b1;
    #2;
    check("ready_mid_rst", 32'(bus.ready), 0);
    @(negedge clk) rst = 1'b0;
    step(8'h00);
    check("rst_exec", 32'(depth_o), 1);
    step(8'h52);
    push_sfr3(10);
    e = 16'h0;
    for (int k = 0; k < 10; k++) e[9-k] = (k % 5) < 2;
    check("timer_2_3", 32'(stack_o), 32'(e));
    step(8'h00);
    step(8'h27);
    check("idle_pre_uo", 32'(uo_out), 32'h80);
    s_snap = stack_o;
    u_snap = uo_out;
    d_snap = depth_o;
    for (int i = 0; i < 10; i++) begin
      bus.instr = 8'($urandom);
      ui_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
    check("idle_stack", 32'(stack_o), 32'(s_snap));
    check("idle_uo", 32'(uo_out), 32'(u_snap));
    check("idle_depth", 32'(depth_o), 32'(d_snap));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
